// File: rtl/stack_sequencer_if.sv
// Byte-wide memory bus between the stack sequencer (master) and the bus interface (slave).
// mem_rdata is expected to be valid combinationally while mem_re is high.
interface stack_sequencer_if;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata
  );
endinterface

// File: rtl/stack_sequencer.sv
// Stack operation sequencer: PUSH/POP/CALL/RET as a series of M-cycle steps, one per cpu_en,
// driving register-file select/write, SP +/-2 strobes, PC load and a byte-wide memory bus.
module stack_sequencer #(
  parameter bit PUSH_INTERNAL = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_en,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [2:0]                rr,
  input  logic [15:0]               pc,
  input  logic [15:0]               target,
  input  logic [15:0]               sp,
  input  logic [15:0]               reg16_rdata,
  stack_sequencer_if.master         bus,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                reg16_src,
  output logic [2:0]                reg16_dst,
  output logic [15:0]               reg16_wdata,
  output logic                      reg16_write,
  output logic                      sp_inc,
  output logic                      sp_dec,
  output logic                      pc_load,
  output logic [15:0]               pc_wdata
);

  typedef enum logic [1:0] {
    OpPush = 2'b00,
    OpPop  = 2'b01,
    OpCall = 2'b10,
    OpRet  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StInt,
    StWrHi,
    StWrLo,
    StRdLo,
    StRdHi,
    StJmp
  } state_e;

  state_e      state_q;
  op_e         op_q;
  logic [2:0]  rr_q;
  logic [15:0] pc_q;
  logic [15:0] target_q;
  logic [15:0] push_data_q;
  logic [7:0]  lo_q;
  logic [7:0]  hi_q;
  logic        busy_q;
  logic        done_q;

  op_e         op_in;
  logic        is_push_like;
  logic        skip_cmd;
  logic        accept;

  assign op_in        = op_e'(op);
  assign is_push_like = (op_in == OpPush) || (op_in == OpCall);
  // PUSH/POP of a selector with bit 2 set has no register behind it: complete with no activity.
  assign skip_cmd     = ((op_in == OpPush) || (op_in == OpPop)) && rr[2];
  assign accept       = (state_q == StIdle) && start && cpu_en;

  // Sequencer state, command latches and the registered busy/done flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= OpPush;
      rr_q        <= 3'd0;
      pc_q        <= 16'd0;
      target_q    <= 16'd0;
      push_data_q <= 16'd0;
      lo_q        <= 8'd0;
      hi_q        <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cpu_en) begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              op_q     <= op_in;
              rr_q     <= rr;
              pc_q     <= pc;
              target_q <= target;
              if (skip_cmd) begin
                done_q <= 1'b1;
              end else if (is_push_like) begin
                busy_q <= 1'b1;
                if (PUSH_INTERNAL) begin
                  state_q <= StInt;
                end else begin
                  state_q     <= StWrHi;
                  push_data_q <= (op_in == OpCall) ? pc : reg16_rdata;
                end
              end else begin
                busy_q  <= 1'b1;
                state_q <= StRdLo;
              end
            end
          end
          StInt: begin
            push_data_q <= (op_q == OpCall) ? pc_q : reg16_rdata;
            state_q     <= StWrHi;
          end
          StWrHi: begin
            state_q <= StWrLo;
          end
          StWrLo: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          StRdLo: begin
            lo_q    <= bus.mem_rdata;
            state_q <= StRdHi;
          end
          StRdHi: begin
            if (op_q == OpRet) begin
              hi_q    <= bus.mem_rdata;
              state_q <= StJmp;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          StJmp: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Without the internal cycle push data is captured on the accept edge, so the register file
  // must already be looking at the incoming selector while idle.
  assign reg16_src = (!PUSH_INTERNAL && (state_q == StIdle)) ? rr : rr_q;
  assign reg16_dst = rr_q;

  // SP only moves on the final bus step, so address offsets are taken from the live sp input.
  always_comb begin
    bus.mem_addr  = 16'd0;
    bus.mem_wdata = 8'd0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    reg16_wdata   = 16'd0;
    reg16_write   = 1'b0;
    sp_inc        = 1'b0;
    sp_dec        = 1'b0;
    pc_load       = 1'b0;
    pc_wdata      = 16'd0;
    unique case (state_q)
      StWrHi: begin
        bus.mem_addr  = sp - 16'd1;
        bus.mem_wdata = push_data_q[15:8];
        bus.mem_we    = cpu_en;
      end
      StWrLo: begin
        bus.mem_addr  = sp - 16'd2;
        bus.mem_wdata = push_data_q[7:0];
        bus.mem_we    = cpu_en;
        sp_dec        = cpu_en;
        if (op_q == OpCall) begin
          pc_load  = cpu_en;
          pc_wdata = target_q;
        end
      end
      StRdLo: begin
        bus.mem_addr = sp;
        bus.mem_re   = cpu_en;
      end
      StRdHi: begin
        bus.mem_addr = sp + 16'd1;
        bus.mem_re   = cpu_en;
        sp_inc       = cpu_en;
        if (op_q == OpPop) begin
          reg16_write = cpu_en;
          reg16_wdata = {bus.mem_rdata, lo_q};
        end
      end
      StJmp: begin
        pc_load  = cpu_en;
        pc_wdata = {hi_q, lo_q};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: acts as memory, register file, SP and PC, and compares the end
// state of each stack operation against the architectural effect of that operation.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic        start;
  logic [1:0]  op;
  logic [2:0]  rr;
  logic [15:0] pc;
  logic [15:0] target;
  logic [15:0] sp;
  logic [15:0] reg16_rdata;
  logic        busy;
  logic        done;
  logic [2:0]  reg16_src;
  logic [2:0]  reg16_dst;
  logic [15:0] reg16_wdata;
  logic        reg16_write;
  logic        sp_inc;
  logic        sp_dec;
  logic        pc_load;
  logic [15:0] pc_wdata;

  always #5 clk = ~clk;

  stack_sequencer_if bus ();

  stack_sequencer #(.PUSH_INTERNAL(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_en      (cpu_en),
    .start       (start),
    .op          (op),
    .rr          (rr),
    .pc          (pc),
    .target      (target),
    .sp          (sp),
    .reg16_rdata (reg16_rdata),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .reg16_src   (reg16_src),
    .reg16_dst   (reg16_dst),
    .reg16_wdata (reg16_wdata),
    .reg16_write (reg16_write),
    .sp_inc      (sp_inc),
    .sp_dec      (sp_dec),
    .pc_load     (pc_load),
    .pc_wdata    (pc_wdata)
  );

  logic [7:0]  mem  [0:65535];
  logic [15:0] regs [0:3];
  logic [15:0] pc_reg;

  assign bus.mem_rdata = mem[bus.mem_addr];
  assign reg16_rdata   = reg16_src[2] ? 16'h0000 : regs[reg16_src[1:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_we, n_re, n_inc, n_dec, n_pcl, n_rw;
  logic [15:0] wa [0:1];
  logic [7:0]  wd [0:1];
  logic [15:0] ra [0:1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic en_of(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 4) == 0;
    return ($urandom % 3) != 0;
  endfunction

  // One clock: observe strobes mid-cycle, then let the environment react to them after the edge.
  task automatic tick();
    logic we, re, inc, dec, pcl, rw;
    logic [15:0] a, rwd, pcw;
    logic [7:0]  d;
    logic [2:0]  dst;
    @(negedge clk);
    if (!cpu_en)
      check("gated_strobes", {26'd0, bus.mem_we, bus.mem_re, reg16_write, sp_inc, sp_dec, pc_load},
            32'd0);
    we = bus.mem_we; re = bus.mem_re; inc = sp_inc; dec = sp_dec; pcl = pc_load;
    rw = reg16_write; a = bus.mem_addr; d = bus.mem_wdata; rwd = reg16_wdata;
    pcw = pc_wdata; dst = reg16_dst;
    @(posedge clk);
    #1;
    if (!reset) begin
      if (we) begin
        mem[a] = d;
        if (n_we < 2) begin wa[n_we] = a; wd[n_we] = d; end
        n_we++;
      end
      if (re) begin
        if (n_re < 2) ra[n_re] = a;
        n_re++;
      end
      if (rw) begin
        if (!dst[2]) regs[dst[1:0]] = rwd;
        n_rw++;
      end
      if (inc) begin sp = sp + 16'd2; n_inc++; end
      if (dec) begin sp = sp - 16'd2; n_dec++; end
      if (pcl) begin pc_reg = pcw; n_pcl++; end
    end
  endtask

  // Steps counted include the accepting step; the internal cycle adds one to PUSH and CALL.
  function automatic int exp_steps(input logic [1:0] o, input logic [2:0] r);
    if ((o == 2'b00 || o == 2'b01) && r[2]) return 1;
    case (o)
      2'b00:   return 4;
      2'b01:   return 3;
      2'b10:   return 4;
      default: return 4;
    endcase
  endfunction

  task automatic run_txn(input logic [1:0] t_op, input logic [2:0] t_rr, input logic [15:0] t_pc,
                         input logic [15:0] t_tgt, input int mode, input bit inject);
    logic [15:0] sp0, pc0, e_val, a_m1, a_m2, a_p1;
    bit skip, accepted, got_done;
    int steps, cyc;
    sp0 = sp; pc0 = pc_reg;
    a_m1 = sp0 - 16'd1; a_m2 = sp0 - 16'd2; a_p1 = sp0 + 16'd1;
    skip = (t_op == 2'b00 || t_op == 2'b01) && t_rr[2];
    n_we = 0; n_re = 0; n_inc = 0; n_dec = 0; n_pcl = 0; n_rw = 0;
    case (t_op)
      2'b00:   e_val = t_rr[2] ? 16'h0 : regs[t_rr[1:0]];
      2'b10:   e_val = t_pc;
      default: e_val = {mem[a_p1], mem[sp0]};
    endcase
    op = t_op; rr = t_rr; pc = t_pc; target = t_tgt; start = 1'b1;
    accepted = 1'b0; cyc = 0;
    for (int i = 0; i < 64 && !accepted; i++) begin
      cpu_en = en_of(mode, cyc); cyc++;
      accepted = cpu_en;
      tick();
    end
    start = 1'b0;
    check("accepted", 32'(accepted), 32'd1);
    check("busy_after_start", 32'(busy), 32'(!skip));
    steps = 1; got_done = done;
    for (int i = 0; i < 200 && !got_done; i++) begin
      cpu_en = en_of(mode, cyc); cyc++;
      if (inject && i == 1) begin start = 1'b1; op = 2'b01; rr = 3'd0; end
      tick();
      start = 1'b0;
      if (cpu_en) steps++;
      got_done = done;
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("steps", 32'(steps), 32'(exp_steps(t_op, t_rr)));
    cpu_en = 1'b0;
    tick();
    check("done_single_pulse", 32'(done), 32'd0);
    check("busy_released", 32'(busy), 32'd0);
    if (skip) begin
      check("skip_activity", 32'(n_we + n_re + n_rw + n_inc + n_dec + n_pcl), 32'd0);
      check("skip_sp", 32'(sp), 32'(sp0));
    end else if (t_op == 2'b00 || t_op == 2'b10) begin
      check("wr_hi_addr", 32'(wa[0]), 32'(a_m1));
      check("wr_hi_data", 32'(wd[0]), 32'(e_val[15:8]));
      check("wr_lo_addr", 32'(wa[1]), 32'(a_m2));
      check("wr_lo_data", 32'(wd[1]), 32'(e_val[7:0]));
      check("push_we_count", 32'(n_we), 32'd2);
      check("push_re_count", 32'(n_re), 32'd0);
      check("push_sp", 32'(sp), 32'(a_m2));
      check("push_dec_count", 32'(n_dec), 32'd1);
      check("push_pc", 32'(pc_reg), 32'((t_op == 2'b10) ? t_tgt : pc0));
    end else begin
      check("rd_lo_addr", 32'(ra[0]), 32'(sp0));
      check("rd_hi_addr", 32'(ra[1]), 32'(a_p1));
      check("pop_re_count", 32'(n_re), 32'd2);
      check("pop_we_count", 32'(n_we), 32'd0);
      check("pop_sp", 32'(sp), 32'(sp0 + 16'd2));
      check("pop_inc_count", 32'(n_inc), 32'd1);
      if (t_op == 2'b01) begin
        check("pop_reg", 32'(regs[t_rr[1:0]]), 32'(e_val));
        check("pop_pc_unchanged", 32'(pc_reg), 32'(pc0));
      end else begin
        check("ret_pc", 32'(pc_reg), 32'(e_val));
        check("ret_no_regwrite", 32'(n_rw), 32'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) regs[i] = 16'($urandom);
    pc_reg = 16'h0100; sp = 16'hFFFE;
    reset = 1'b1; cpu_en = 1'b0; start = 1'b0; op = 2'b00; rr = 3'd0;
    pc = 16'h0; target = 16'h0;
    n_we = 0; n_re = 0; n_inc = 0; n_dec = 0; n_pcl = 0; n_rw = 0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_src", 32'(reg16_src), 32'd0);
    check("rst_pc_wdata", 32'(pc_wdata), 32'd0);

    // start without cpu_en must not be taken
    start = 1'b1; op = 2'b00; rr = 3'd0; cpu_en = 1'b0;
    tick();
    check("no_accept_busy", 32'(busy), 32'd0);
    tick();
    check("no_accept_busy2", 32'(busy), 32'd0);
    start = 1'b0;

    // PUSH BC with a stray start mid-operation
    regs[0] = 16'h1234; sp = 16'hFFFE;
    run_txn(2'b00, 3'd0, 16'h0, 16'h0, 0, 1'b1);
    check("push_mem_fffd", 32'(mem[16'hFFFD]), 32'h12);
    check("push_mem_fffc", 32'(mem[16'hFFFC]), 32'h34);

    // POP AF
    sp = 16'hFFFC; mem[16'hFFFC] = 8'hF0; mem[16'hFFFD] = 8'h01;
    run_txn(2'b01, 3'd3, 16'h0, 16'h0, 0, 1'b0);
    check("pop_af", 32'(regs[3]), 32'h01F0);

    // CALL across the address wrap
    sp = 16'h0000;
    run_txn(2'b10, 3'd0, 16'h0153, 16'h0200, 0, 1'b0);
    check("call_mem_ffff", 32'(mem[16'hFFFF]), 32'h01);
    check("call_mem_fffe", 32'(mem[16'hFFFE]), 32'h53);
    check("call_pc", 32'(pc_reg), 32'h0200);

    // RET with cpu_en every fourth clock
    sp = 16'hFFFC; mem[16'hFFFC] = 8'h53; mem[16'hFFFD] = 8'h01;
    run_txn(2'b11, 3'd0, 16'h0, 16'h0, 1, 1'b0);
    check("ret_pc_0153", 32'(pc_reg), 32'h0153);

    // Reset while PUSH sits in WR_HI
    regs[0] = 16'hABCD; sp = 16'h1000;
    start = 1'b1; op = 2'b00; rr = 3'd0; cpu_en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("wrhi_we", 32'(bus.mem_we), 32'd1);
    check("wrhi_addr", 32'(bus.mem_addr), 32'h0FFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_sp", 32'(sp), 32'h1000);
    cpu_en = 1'b1;
    tick();
    check("mid_rst_no_done", 32'(done), 32'd0);
    check("mid_rst_no_dec", 32'(sp_dec), 32'd0);
    run_txn(2'b00, 3'd0, 16'h0, 16'h0, 0, 1'b0);

    // POP with an unbacked selector
    sp = 16'h2000;
    run_txn(2'b01, 3'd4, 16'h0, 16'h0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] r_op;
      logic [2:0] r_rr;
      r_op = 2'($urandom);
      r_rr = 3'($urandom);
      sp = 16'($urandom);
      run_txn(r_op, r_rr, 16'($urandom), 16'($urandom), 2,
              (r_op == 2'b00) && !r_rr[2] && (($urandom % 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
